ahb_arbiter: RTL
================

Name: ahb_arbiter

Overview:
- Burst-aware round-robin arbiter sharing one AHB bus among MASTER_NUM masters.
- Issues one-hot hgrant and drives hmaster/hmastlock to the address/data mux.
- Monitors muxed htrans/hburst/hready so fixed-length bursts (INCR4..WRAP16) and locked sequences are never broken by re-arbitration.

Parameters:
MASTER_NUM, 4, number of requesting masters (2..16)
DEFAULT_MASTER, 0, master granted when nobody requests; also the reset owner

Ports:
hclk  input  1  bus clock
hresetn  input  1  asynchronous active-low reset
hbusreq  input  MASTER_NUM  per-master bus request
hlock  input  MASTER_NUM  per-master locked-access request
htrans  input  2  muxed transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
hburst  input  3  muxed burst type (ahb_burst_type encoding)
hready  input  1  bus ready
hgrant  output  MASTER_NUM  one-hot grant
hmaster  output  $clog2(MASTER_NUM)  index of master owning the address phase
hmastlock  output  1  current address phase is locked

Behaviour:
- One clock (hclk); reset is asynchronous and active-low (hresetn).
- Reset values: hgrant = one-hot DEFAULT_MASTER, hmaster = DEFAULT_MASTER, hmastlock = 0, state = ARB, beats_left = 0, rr pointer = DEFAULT_MASTER.
- All outputs are registered. Nothing changes in a cycle with hready = 0, except that reset is always honoured.
- Pick: round-robin search from (owner+1) mod MASTER_NUM over hbusreq. No requests gives DEFAULT_MASTER.
- hgrant <= one-hot(pick) when hready && arb_open. The rr pointer moves to pick.
- hmaster <= index(hgrant) and hmastlock <= hlock[index(hgrant)] on hready. hmaster therefore lags hgrant by one hready cycle.
- States:
  - ARB: no fixed burst in progress.
  - FIXED: fixed-length burst in progress; beats_left counts the remaining address beats.
  - LOCK: owner holds hlock.
- ARB to FIXED: hready && htrans==NONSEQ && get_burst_len(hburst) > 1. Load beats_left = len-1.
- FIXED: hready && htrans==SEQ decrements beats_left. BUSY and hready=0 hold it.
- FIXED to ARB on either:
  - hready && htrans==SEQ && beats_left==1 (last address beat accepted); or
  - early termination: hready && htrans==IDLE.
- FIXED, hready && htrans==NONSEQ: new burst. Reload beats_left from the new hburst and stay in FIXED (or go to ARB if SINGLE/INCR).
- Any state to LOCK: hready && hlock[owner]=1, where owner = index(hgrant). LOCK to ARB when hlock[owner] drops with hready=1, unless a fixed burst is still counting (then FIXED). The LOCK priority still tracks beats.
- arb_open is true in exactly these cases:
  - ARB, owner not INCR-holding, and the current cycle does not start a fixed burst.
  - FIXED on the last-beat acceptance cycle (grant handover overlaps the last beat).
  - The early-termination cycle.
- INCR hold: in ARB, if hburst==INCR, htrans is NONSEQ/SEQ/BUSY, and hbusreq[owner]=1, then arb_open = 0.
- LOCK: arb_open = 0 always.
- Requester dropping hbusreq mid fixed burst: ignored until the burst ends.
- Owner requesting again after handover: waits its round-robin turn.
- Reset mid-burst: immediate return to the reset values; no burst is resumed.
- Width rule: beats_left is 5 bits; len comes from get_burst_len (INCR = 0, SINGLE = 1).

Optional Feature:
AHB_ARB_FIXED_PRIO_EN
- Defined: pick = lowest-index requesting master; the rr pointer is unused. Starvation is possible and accepted.
- Undefined: round-robin as above.
- Burst/lock holding rules are identical in both modes.

Decomposition:
- ahb_pkg gets:
  - new ahb_trans_type enum (AHB_TRANS_IDLE/BUSY/NONSEQ/SEQ);
  - arbiter state enum ahb_arb_state (ARB, FIXED, LOCK).
- ahb_pkg reuses ahb_burst_type and get_burst_len.
- One sub-module, ahb_rr_picker: combinational request vector + pointer -> one-hot pick and valid. The fixed-priority variant lives behind the macro inside it.

Test Plan:
- Reset, no requests -> hgrant=4'b0001, hmaster=0, hmastlock=0.
- hbusreq=4'b0110 held, all SINGLE transfers -> grants alternate M1, M2, M1, M2 on successive hready cycles.
- M1 issues INCR8 while M2 requests -> hgrant stays M1 for 7 SEQ acceptances. It moves to M2 in the cycle the 8th address is accepted. Inserting 2 BUSY and 3 hready=0 cycles extends the hold accordingly.
- M2 issues INCR4 then IDLE after 2 beats (early termination) -> state returns to ARB and the grant moves to the next requester (M3 if requesting).
- M3 asserts hlock with hbusreq=4'b1111 across three INCR4 bursts -> hgrant stays M3 and hmastlock=1 throughout. Release happens one hready cycle after hlock drops.
- hresetn pulsed low during a WRAP16 at beat 5 -> outputs return to reset values asynchronously. A subsequent NONSEQ restarts counting from 15.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB type definitions and burst helpers for the bus arbiter.
package ahb_pkg;

    typedef enum logic [2:0] {
        AHB_BURST_SINGLE = 3'd0,
        AHB_BURST_INCR   = 3'd1,
        AHB_BURST_WRAP4  = 3'd2,
        AHB_BURST_INCR4  = 3'd3,
        AHB_BURST_WRAP8  = 3'd4,
        AHB_BURST_INCR8  = 3'd5,
        AHB_BURST_WRAP16 = 3'd6,
        AHB_BURST_INCR16 = 3'd7
    } ahb_burst_type;

    typedef enum logic [1:0] {
        AHB_TRANS_IDLE   = 2'd0,
        AHB_TRANS_BUSY   = 2'd1,
        AHB_TRANS_NONSEQ = 2'd2,
        AHB_TRANS_SEQ    = 2'd3
    } ahb_trans_type;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        FIXED = 2'd1,
        LOCK  = 2'd2
    } ahb_arb_state;

    localparam int AHB_BEAT_W = 5;

    // Undefined-length INCR reports 0 so it never looks like a fixed burst.
    function automatic logic [AHB_BEAT_W-1:0] get_burst_len(input ahb_burst_type burst);
        case (burst)
            AHB_BURST_SINGLE:                  return 5'd1;
            AHB_BURST_INCR:                    return 5'd0;
            AHB_BURST_WRAP4,  AHB_BURST_INCR4:  return 5'd4;
            AHB_BURST_WRAP8,  AHB_BURST_INCR8:  return 5'd8;
            AHB_BURST_WRAP16, AHB_BURST_INCR16: return 5'd16;
            default:                           return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational next-owner picker: round-robin after ptr, or lowest index
// when AHB_ARB_FIXED_PRIO_EN is defined.
module ahb_rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] pick,
    output logic [W-1:0] pick_idx,
    output logic         valid
);

`ifdef AHB_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        pick_idx = '0;
        valid    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_idx = W'(i);
                valid    = 1'b1;
            end
        end
    end
`else
    logic [N-1:0] rot_req;
    logic [W-1:0] rot_idx [N];

    // Slot gi of the rotated view is master (ptr + 1 + gi) mod N.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        logic [W:0] sum;
        assign sum          = {1'b0, ptr} + (W+1)'(gi + 1);
        assign rot_idx[gi]  = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
        assign rot_req[gi]  = req[rot_idx[gi]];
    end

    always_comb begin
        pick_idx = '0;
        valid    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                pick_idx = rot_idx[i];
                valid    = 1'b1;
            end
        end
    end
`endif

    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
        assign pick[gi] = valid && (pick_idx == W'(gi));
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Burst/lock-aware AHB bus arbiter. Define AHB_ARB_FIXED_PRIO_EN for
// lowest-index-wins priority instead of round-robin.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int MASTER_NUM     = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                          hclk,
    input  logic                          hresetn,
    input  logic [MASTER_NUM-1:0]         hbusreq,
    input  logic [MASTER_NUM-1:0]         hlock,
    input  logic [1:0]                    htrans,
    input  logic [2:0]                    hburst,
    input  logic                          hready,
    output logic [MASTER_NUM-1:0]         hgrant,
    output logic [$clog2(MASTER_NUM)-1:0] hmaster,
    output logic                          hmastlock
);

    localparam int MW = $clog2(MASTER_NUM);
    localparam logic [MASTER_NUM-1:0] DEFAULT_ONEHOT = MASTER_NUM'(1) << DEFAULT_MASTER;
    localparam logic [MW-1:0]         DEFAULT_IDX    = MW'(DEFAULT_MASTER);

    ahb_arb_state            state_reg, state_next;
    logic [AHB_BEAT_W-1:0]   beats_left_reg, beats_left_next;
    logic [MASTER_NUM-1:0]   hgrant_reg, hgrant_next;
    logic [MW-1:0]           owner_reg, owner_next;
    logic [MW-1:0]           rr_ptr_reg, rr_ptr_next;
    logic [MW-1:0]           hmaster_reg, hmaster_next;
    logic                    hmastlock_reg, hmastlock_next;

    logic [MASTER_NUM-1:0]   picker_pick;
    logic [MW-1:0]           picker_idx;
    logic                    picker_valid;
    logic [MASTER_NUM-1:0]   pick_vec;
    logic [MW-1:0]           pick_idx;

    ahb_trans_type           trans;
    ahb_burst_type           burst;
    logic [AHB_BEAT_W-1:0]   burst_len;
    logic                    in_burst;
    logic                    starts_fixed;
    logic                    last_beat;
    logic                    early_term;
    logic                    incr_hold;
    logic                    arb_open;

    ahb_rr_picker #(
        .N (MASTER_NUM),
        .W (MW)
    ) u_picker (
        .req      (hbusreq),
        .ptr      (rr_ptr_reg),
        .pick     (picker_pick),
        .pick_idx (picker_idx),
        .valid    (picker_valid)
    );

    assign pick_vec = picker_valid ? picker_pick : DEFAULT_ONEHOT;
    assign pick_idx = picker_valid ? picker_idx  : DEFAULT_IDX;

    assign trans        = ahb_trans_type'(htrans);
    assign burst        = ahb_burst_type'(hburst);
    assign burst_len    = get_burst_len(burst);
    assign in_burst     = (beats_left_reg != '0);
    assign starts_fixed = (trans == AHB_TRANS_NONSEQ) && (burst_len > 5'd1);
    assign last_beat    = in_burst && (trans == AHB_TRANS_SEQ) && (beats_left_reg == 5'd1);
    assign early_term   = in_burst && (trans == AHB_TRANS_IDLE);
    // An owner still requesting through an undefined-length INCR keeps the bus.
    assign incr_hold    = (burst == AHB_BURST_INCR) && (trans != AHB_TRANS_IDLE) && hbusreq[owner_reg];

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_reg      <= ARB;
            beats_left_reg <= '0;
            hgrant_reg     <= DEFAULT_ONEHOT;
            owner_reg      <= DEFAULT_IDX;
            rr_ptr_reg     <= DEFAULT_IDX;
            hmaster_reg    <= DEFAULT_IDX;
            hmastlock_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            beats_left_reg <= beats_left_next;
            hgrant_reg     <= hgrant_next;
            owner_reg      <= owner_next;
            rr_ptr_reg     <= rr_ptr_next;
            hmaster_reg    <= hmaster_next;
            hmastlock_reg  <= hmastlock_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        beats_left_next = beats_left_reg;
        hgrant_next     = hgrant_reg;
        owner_next      = owner_reg;
        rr_ptr_next     = rr_ptr_reg;
        hmaster_next    = hmaster_reg;
        hmastlock_next  = hmastlock_reg;
        arb_open        = 1'b0;

        if (hready) begin
            if (trans == AHB_TRANS_NONSEQ) begin
                beats_left_next = (burst_len > 5'd1) ? (burst_len - 5'd1) : 5'd0;
            end else if (in_burst && (trans == AHB_TRANS_SEQ)) begin
                beats_left_next = beats_left_reg - 5'd1;
            end else if (early_term) begin
                beats_left_next = '0;
            end

            case (state_reg)
                ARB:     arb_open = !incr_hold && !starts_fixed;
                FIXED:   arb_open = last_beat || early_term;
                LOCK:    arb_open = 1'b0;
                default: arb_open = 1'b0;
            endcase

            if (hlock[owner_reg]) begin
                state_next = LOCK;
            end else if (beats_left_next != '0) begin
                state_next = FIXED;
            end else begin
                state_next = ARB;
            end

            // Grant handover overlaps the last accepted beat of the old owner.
            if (arb_open) begin
                hgrant_next = pick_vec;
                owner_next  = pick_idx;
                rr_ptr_next = pick_idx;
            end

            hmaster_next   = owner_reg;
            hmastlock_next = hlock[owner_reg];
        end
    end

    assign hgrant    = hgrant_reg;
    assign hmaster   = hmaster_reg;
    assign hmastlock = hmastlock_reg;

endmodule
